// File: rtl/data_wb_bridge.sv
// Core data port to pipelined Wishbone B4 master bridge.
// Handles byte-lane steering, alignment checks, bus timeout and read-data alignment.
module data_wb_bridge #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_W           = 7
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        cpu_stb_in,
    input  logic        cpu_we_in,
    input  logic [1:0]  cpu_be_in,
    input  logic [31:0] cpu_addr_in,
    input  logic [31:0] cpu_data_in,
    output logic [31:0] cpu_data_out,
    output logic        cpu_ack_out,
    output logic        cpu_err_out,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_stall_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t      state_q;
    logic        we_q;
    logic [1:0]  be_q;
    logic [31:0] addr_q;
    logic [31:0] wdat_q;
    logic [3:0]  sel_q;
    logic [TO_W-1:0] cnt_q;
    logic        wb_cyc_q;
    logic        wb_stb_q;
    logic        cpu_ack_q;
    logic        cpu_err_q;
    logic [31:0] cpu_data_q;

    logic        misaligned;
    logic        busDone;
    logic        timeoutHit;
    logic [31:0] readData;

    function automatic logic [3:0] laneSel(input logic [1:0] be, input logic [1:0] o);
        case (be)
            2'b00:   laneSel = 4'b0001 << o;
            2'b01:   laneSel = 4'b0011 << {o[1], 1'b0};
            default: laneSel = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] laneData(input logic [31:0] d, input logic [1:0] be);
        case (be)
            2'b00:   laneData = {4{d[7:0]}};
            2'b01:   laneData = {2{d[15:0]}};
            default: laneData = d;
        endcase
    endfunction

    function automatic logic [31:0] alignRead(input logic [31:0] d, input logic [1:0] be,
                                              input logic [1:0] o);
        logic [31:0] sh;
        sh = d >> {o, 3'b000};
        case (be)
            2'b00:   alignRead = {24'h0, sh[7:0]};
            2'b01:   alignRead = {16'h0, sh[15:0]};
            default: alignRead = sh;
        endcase
    endfunction

    assign misaligned = (cpu_be_in == 2'b11)
                     || ((cpu_be_in == 2'b01) && cpu_addr_in[0])
                     || ((cpu_be_in == 2'b10) && (cpu_addr_in[1:0] != 2'b00));
    assign busDone    = wb_ack_i || wb_err_i;
    assign timeoutHit = (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign readData   = alignRead(wb_dat_i, be_q, addr_q[1:0]);

    // A termination reports an error unless it is a clean ack; data only survives a clean ack.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            be_q       <= 2'b00;
            addr_q     <= '0;
            wdat_q     <= '0;
            sel_q      <= '0;
            cnt_q      <= '0;
            wb_cyc_q   <= 1'b0;
            wb_stb_q   <= 1'b0;
            cpu_ack_q  <= 1'b0;
            cpu_err_q  <= 1'b0;
            cpu_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_stb_in) begin
                        we_q   <= cpu_we_in;
                        be_q   <= cpu_be_in;
                        addr_q <= cpu_addr_in;
                        wdat_q <= laneData(cpu_data_in, cpu_be_in);
                        sel_q  <= laneSel(cpu_be_in, cpu_addr_in[1:0]);
                        if (misaligned) begin
                            state_q    <= RESP;
                            cpu_ack_q  <= 1'b1;
                            cpu_err_q  <= 1'b1;
                            cpu_data_q <= '0;
                        end else begin
                            state_q  <= REQ;
                            wb_cyc_q <= 1'b1;
                            wb_stb_q <= 1'b1;
                            cnt_q    <= '0;
                        end
                    end
                end
                REQ: begin
                    if (!wb_stall_i) begin
                        wb_stb_q <= 1'b0;
                        if (busDone) begin
                            state_q    <= RESP;
                            wb_cyc_q   <= 1'b0;
                            cpu_ack_q  <= 1'b1;
                            cpu_err_q  <= wb_err_i;
                            cpu_data_q <= wb_err_i ? 32'h0 : readData;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (busDone || timeoutHit) begin
                        state_q    <= RESP;
                        wb_cyc_q   <= 1'b0;
                        cpu_ack_q  <= 1'b1;
                        cpu_err_q  <= wb_err_i || !wb_ack_i;
                        cpu_data_q <= (wb_ack_i && !wb_err_i) ? readData : 32'h0;
                    end else begin
                        cnt_q <= cnt_q + TO_W'(1);
                    end
                end
                RESP: begin
                    state_q    <= IDLE;
                    cpu_ack_q  <= 1'b0;
                    cpu_err_q  <= 1'b0;
                    cpu_data_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_ack_out  = cpu_ack_q;
    assign cpu_err_out  = cpu_err_q;
    assign cpu_data_out = cpu_data_q;
    assign wb_cyc_o     = wb_cyc_q;
    assign wb_stb_o     = wb_stb_q;
    assign wb_we_o      = wb_cyc_q & we_q;
    assign wb_sel_o     = wb_cyc_q ? sel_q : 4'b0000;
    assign wb_adr_o     = wb_cyc_q ? {addr_q[31:2], 2'b00} : 32'h0;
    assign wb_dat_o     = (wb_cyc_q & we_q) ? wdat_q : 32'h0;

endmodule

// File: tb/tb_data_wb_bridge.sv
// Directed vector bench for data_wb_bridge: a table of single transfers with an
// immediate-ack slave, plus hand-built stall, timeout, bus-error and reset sequences.
module tb_data_wb_bridge;

    logic        sys_clk;
    logic        sys_rst;
    logic        cpu_stb_in;
    logic        cpu_we_in;
    logic [1:0]  cpu_be_in;
    logic [31:0] cpu_addr_in;
    logic [31:0] cpu_data_in;
    logic [31:0] cpu_data_out;
    logic        cpu_ack_out;
    logic        cpu_err_out;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        wb_stall_i;

    data_wb_bridge #(.TIMEOUT_CYCLES(64), .TO_W(7)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .cpu_stb_in   (cpu_stb_in),
        .cpu_we_in    (cpu_we_in),
        .cpu_be_in    (cpu_be_in),
        .cpu_addr_in  (cpu_addr_in),
        .cpu_data_in  (cpu_data_in),
        .cpu_data_out (cpu_data_out),
        .cpu_ack_out  (cpu_ack_out),
        .cpu_err_out  (cpu_err_out),
        .wb_cyc_o     (wb_cyc_o),
        .wb_stb_o     (wb_stb_o),
        .wb_we_o      (wb_we_o),
        .wb_sel_o     (wb_sel_o),
        .wb_adr_o     (wb_adr_o),
        .wb_dat_o     (wb_dat_o),
        .wb_dat_i     (wb_dat_i),
        .wb_ack_i     (wb_ack_i),
        .wb_err_i     (wb_err_i),
        .wb_stall_i   (wb_stall_i)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        we;
        logic [1:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        expBus;
        logic [3:0]  expSel;
        logic [31:0] expAdr;
        logic [31:0] expDat;
        logic [31:0] expData;
        logic        expErr;
        int          expLat;
    } vec_t;

    vec_t vecs[13];

    int vectorCount = 0;
    int missCount   = 0;

    int          obsLat;
    int          obsStb;
    int          obsWait;
    int          obsAcks;
    logic [31:0] obsData;
    logic        obsErr;
    logic        obsCyc;
    logic        obsStable;
    logic        obsWe;
    logic [3:0]  obsSel;
    logic [31:0] obsAdr;
    logic [31:0] obsDat;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectorCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // mode: 0 ack, 1 wb_err, 2 silent slave, 3 ack and err together
    task automatic applyStimulus(input logic we, input logic [1:0] be, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input int stallN, input int mode);
        int  extra;
        bit  done;
        obsLat = -1; obsStb = 0; obsWait = 0; obsAcks = 0;
        obsData = '0; obsErr = 1'b0; obsCyc = 1'b0; obsStable = 1'b1;
        obsWe = 1'b0; obsSel = '0; obsAdr = '0; obsDat = '0;
        done = 1'b0; extra = 0;
        @(negedge sys_clk);
        cpu_stb_in  = 1'b1;
        cpu_we_in   = we;
        cpu_be_in   = be;
        cpu_addr_in = addr;
        cpu_data_in = wdata;
        wb_dat_i    = rdata;
        wb_stall_i  = (stallN > 0);
        for (int k = 1; k <= 200 && extra < 4; k++) begin
            @(negedge sys_clk);
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            if (wb_cyc_o) obsCyc = 1'b1;
            if (wb_cyc_o && wb_stb_o) begin
                obsStb++;
                if (obsStb == 1) begin
                    obsSel = wb_sel_o; obsAdr = wb_adr_o; obsDat = wb_dat_o; obsWe = wb_we_o;
                end else if (wb_sel_o !== obsSel || wb_adr_o !== obsAdr) begin
                    obsStable = 1'b0;
                end
                if (obsStb > stallN) wb_stall_i = 1'b0;
            end else if (wb_cyc_o) begin
                obsWait++;
                if (obsWait == 1) begin
                    wb_ack_i = (mode == 0) || (mode == 3);
                    wb_err_i = (mode == 1) || (mode == 3);
                end
            end
            if (cpu_ack_out) begin
                obsAcks++;
                if (!done) begin
                    obsLat = k; obsData = cpu_data_out; obsErr = cpu_err_out;
                end
                done = 1'b1;
                cpu_stb_in = 1'b0;
            end
            if (done) extra++;
        end
        cpu_stb_in = 1'b0;
        wb_stall_i = 1'b0;
        wb_ack_i   = 1'b0;
        wb_err_i   = 1'b0;
    endtask

    initial begin
        // we be addr wdata rdata | bus sel adr dat data err lat
        vecs[0]  = '{1'b0, 2'b10, 32'h100, 32'h0,        32'hDEADBEEF, 1'b1, 4'hF, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 3};
        vecs[1]  = '{1'b1, 2'b00, 32'h203, 32'h123456A5, 32'h0,        1'b1, 4'h8, 32'h200, 32'hA5A5A5A5, 32'h0,        1'b0, 3};
        vecs[2]  = '{1'b0, 2'b01, 32'h202, 32'h0,        32'h12345678, 1'b1, 4'hC, 32'h200, 32'h0,        32'h00001234, 1'b0, 3};
        vecs[3]  = '{1'b0, 2'b00, 32'h101, 32'h0,        32'h11223344, 1'b1, 4'h2, 32'h100, 32'h0,        32'h00000033, 1'b0, 3};
        vecs[4]  = '{1'b1, 2'b01, 32'h300, 32'hBEEF12CD, 32'h0,        1'b1, 4'h3, 32'h300, 32'h12CD12CD, 32'h0,        1'b0, 3};
        vecs[5]  = '{1'b1, 2'b10, 32'h404, 32'hCAFEF00D, 32'h0,        1'b1, 4'hF, 32'h404, 32'hCAFEF00D, 32'h0,        1'b0, 3};
        vecs[6]  = '{1'b0, 2'b00, 32'h000, 32'h0,        32'h11223344, 1'b1, 4'h1, 32'h000, 32'h0,        32'h00000044, 1'b0, 3};
        vecs[7]  = '{1'b0, 2'b00, 32'h003, 32'h0,        32'hA1B2C3D4, 1'b1, 4'h8, 32'h000, 32'h0,        32'h000000A1, 1'b0, 3};
        vecs[8]  = '{1'b0, 2'b01, 32'h200, 32'h0,        32'h12345678, 1'b1, 4'h3, 32'h200, 32'h0,        32'h00005678, 1'b0, 3};
        vecs[9]  = '{1'b0, 2'b01, 32'h101, 32'h0,        32'hFFFFFFFF, 1'b0, 4'h0, 32'h0,   32'h0,        32'h0,        1'b1, 1};
        vecs[10] = '{1'b0, 2'b10, 32'h102, 32'h0,        32'hFFFFFFFF, 1'b0, 4'h0, 32'h0,   32'h0,        32'h0,        1'b1, 1};
        vecs[11] = '{1'b0, 2'b11, 32'h100, 32'h0,        32'hFFFFFFFF, 1'b0, 4'h0, 32'h0,   32'h0,        32'h0,        1'b1, 1};
        vecs[12] = '{1'b1, 2'b10, 32'h203, 32'h55555555, 32'hFFFFFFFF, 1'b0, 4'h0, 32'h0,   32'h0,        32'h0,        1'b1, 1};

        sys_rst = 1'b1;
        cpu_stb_in = 1'b0; cpu_we_in = 1'b0; cpu_be_in = 2'b00;
        cpu_addr_in = '0; cpu_data_in = '0;
        wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_stall_i = 1'b0;
        repeat (2) @(negedge sys_clk);
        checkOutput("rst.cyc",  {31'h0, wb_cyc_o},    32'h0);
        checkOutput("rst.stb",  {31'h0, wb_stb_o},    32'h0);
        checkOutput("rst.ack",  {31'h0, cpu_ack_out}, 32'h0);
        checkOutput("rst.err",  {31'h0, cpu_err_out}, 32'h0);
        checkOutput("rst.data", cpu_data_out,         32'h0);
        checkOutput("rst.sel",  {28'h0, wb_sel_o},    32'h0);
        checkOutput("rst.adr",  wb_adr_o,             32'h0);
        sys_rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, 0, 0);
            checkOutput($sformatf("v%0d.lat", i),  obsLat,                  vecs[i].expLat);
            checkOutput($sformatf("v%0d.data", i), obsData,                 vecs[i].expData);
            checkOutput($sformatf("v%0d.err", i),  {31'h0, obsErr},         {31'h0, vecs[i].expErr});
            checkOutput($sformatf("v%0d.acks", i), obsAcks,                 1);
            checkOutput($sformatf("v%0d.cyc", i),  {31'h0, obsCyc},         {31'h0, vecs[i].expBus});
            if (vecs[i].expBus) begin
                checkOutput($sformatf("v%0d.sel", i), {28'h0, obsSel},      {28'h0, vecs[i].expSel});
                checkOutput($sformatf("v%0d.adr", i), obsAdr,               vecs[i].expAdr);
                checkOutput($sformatf("v%0d.we", i),  {31'h0, obsWe},       {31'h0, vecs[i].we});
                checkOutput($sformatf("v%0d.stbs", i), obsStb,              1);
                if (vecs[i].we) checkOutput($sformatf("v%0d.dat", i), obsDat, vecs[i].expDat);
            end
        end

        applyStimulus(1'b0, 2'b10, 32'h500, 32'h0, 32'h0BADF00D, 5, 0);
        checkOutput("stall.stbs",   obsStb,              6);
        checkOutput("stall.stable", {31'h0, obsStable},  32'h1);
        checkOutput("stall.adr",    obsAdr,              32'h500);
        checkOutput("stall.acks",   obsAcks,             1);
        checkOutput("stall.lat",    obsLat,              8);
        checkOutput("stall.data",   obsData,             32'h0BADF00D);

        applyStimulus(1'b0, 2'b10, 32'h700, 32'h0, 32'h77777777, 0, 2);
        checkOutput("tmo.wait", obsWait,         64);
        checkOutput("tmo.lat",  obsLat,          66);
        checkOutput("tmo.err",  {31'h0, obsErr}, 32'h1);
        checkOutput("tmo.data", obsData,         32'h0);
        checkOutput("tmo.acks", obsAcks,         1);

        applyStimulus(1'b0, 2'b10, 32'h600, 32'h0, 32'h55555555, 0, 1);
        checkOutput("wberr.lat",  obsLat,          3);
        checkOutput("wberr.err",  {31'h0, obsErr}, 32'h1);
        checkOutput("wberr.data", obsData,         32'h0);

        applyStimulus(1'b0, 2'b10, 32'h610, 32'h0, 32'h66666666, 0, 3);
        checkOutput("both.err",  {31'h0, obsErr}, 32'h1);
        checkOutput("both.data", obsData,         32'h0);

        @(negedge sys_clk);
        cpu_stb_in = 1'b1; cpu_we_in = 1'b0; cpu_be_in = 2'b10;
        cpu_addr_in = 32'h900; wb_dat_i = 32'h99999999;
        repeat (2) @(negedge sys_clk);
        checkOutput("rstw.cycBefore", {31'h0, wb_cyc_o}, 32'h1);
        checkOutput("rstw.stbBefore", {31'h0, wb_stb_o}, 32'h0);
        #2 sys_rst = 1'b1;
        #1;
        checkOutput("rstw.cyc", {31'h0, wb_cyc_o},    32'h0);
        checkOutput("rstw.ack", {31'h0, cpu_ack_out}, 32'h0);
        checkOutput("rstw.sel", {28'h0, wb_sel_o},    32'h0);
        cpu_stb_in = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;

        applyStimulus(1'b0, 2'b10, 32'h800, 32'h0, 32'h13579BDF, 0, 0);
        checkOutput("fresh.lat",  obsLat,          3);
        checkOutput("fresh.data", obsData,         32'h13579BDF);
        checkOutput("fresh.err",  {31'h0, obsErr}, 32'h0);
        checkOutput("fresh.acks", obsAcks,         1);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
